cci_mpf_vtp_inval_sequencer: RTL and testbench

Sequences VTP single-page translation invalidations requested by host MMIO writes. It buffers the requested line addresses in a small FIFO and drives them one at a time onto the VTP invalidate inputs. After each issue it waits for the VTP completion toggle before issuing the next. It sits between the MPF CSR manager and the VTP shim's invalidation port, and supplies status and counters for CSR readback.

---
 rtl/cci_mpf_csrs_pkg.sv | 20 ++
 rtl/cci_mpf_prim_fifo_lutram.sv | 66 ++++++
 rtl/cci_mpf_vtp_inval_sequencer.sv | 155 +++++++++++++++
 tb/tb_cci_mpf_vtp_inval_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_csrs_pkg.sv
// Shared CSR-side types and defaults for the MPF VTP invalidation path.
package cci_mpf_csrs_pkg;

  // CCI-P cache-line address width
  localparam int unsigned CCI_CLADDR_WIDTH = 42;
  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;

  // Invalidation sequencer FSM states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } t_cci_mpf_vtp_inval_state;

  // Default request FIFO depth
  localparam int unsigned VTP_INVAL_N_ENTRIES_DEFAULT = 8;

  // Default completion wait limit in cycles
  localparam int unsigned VTP_INVAL_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Small distributed-RAM FIFO of line addresses with occupancy and full flags.
// A push while full is accepted only when a pop happens in the same cycle.
module cci_mpf_prim_fifo_lutram
  import cci_mpf_csrs_pkg::*;
#(
  parameter int unsigned N_ENTRIES = VTP_INVAL_N_ENTRIES_DEFAULT
)
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_push,
  input  t_cci_clAddr                 i_push_data,
  input  logic                        i_pop,
  output t_cci_clAddr                 o_head,
  output logic [$clog2(N_ENTRIES):0]  o_count,
  output logic                        o_full
);

  localparam int unsigned PTR_W = $clog2(N_ENTRIES);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(N_ENTRIES);

  t_cci_clAddr        r_mem [N_ENTRIES];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_full;
  logic               w_pop_ok;
  logic               w_push_ok;

  assign w_full    = (r_count == FULL_CNT);
  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule

// File: rtl/cci_mpf_vtp_inval_sequencer.sv
// Issues buffered single-page VTP invalidations one at a time, waiting for
// the completion toggle (or a timeout) between issues.
module cci_mpf_vtp_inval_sequencer
  import cci_mpf_csrs_pkg::*;
#(
  parameter int unsigned N_ENTRIES      = VTP_INVAL_N_ENTRIES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = VTP_INVAL_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH      = 16
)
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  t_cci_clAddr          req_addr,
  output t_cci_clAddr          inval_page,
  output logic                 inval_page_valid,
  input  logic                 inval_complete_toggle,
  input  logic                 status_clear,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 overflow_err,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] done_count
);

  localparam int unsigned OCC_W = $clog2(N_ENTRIES) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  t_cci_mpf_vtp_inval_state r_state;
  t_cci_mpf_vtp_inval_state w_state_nxt;

  t_cci_clAddr          w_fifo_head;
  logic [OCC_W-1:0]     w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  logic                 w_pop;
  logic                 w_complete;
  logic                 w_timeout;
  logic                 w_ovf_set;

  logic                 r_ref_tgl;
  logic [TMO_W-1:0]     r_wait_cnt;
  t_cci_clAddr          r_inval_page;
  logic                 r_inval_valid;
  logic [CNT_WIDTH-1:0] r_done_count;
  logic                 r_overflow_err;
  logic                 r_timeout_err;

  cci_mpf_prim_fifo_lutram #(
    .N_ENTRIES (N_ENTRIES)
  ) u_req_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (req_valid),
    .i_push_data (req_addr),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full)
  );

  assign w_fifo_empty = (w_fifo_count == '0);

  // Dropped only when full and the head is not leaving this cycle
  assign w_ovf_set = req_valid && w_fifo_full && !w_pop;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and issue/complete/timeout decisions
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Completion is checked first so it beats a simultaneous timeout
        if (inval_complete_toggle != r_ref_tgl) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_wait_cnt == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Issue register, toggle reference and wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inval_page  <= '0;
      r_inval_valid <= 1'b0;
      r_ref_tgl     <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_inval_valid <= w_pop;
      if (w_pop) begin
        r_inval_page <= w_fifo_head;
        r_ref_tgl    <= inval_complete_toggle;
        r_wait_cnt   <= '0;
      end else if ((r_state == WAIT) && !w_complete && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  // Completion counter and sticky error flags (set beats clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_count   <= '0;
      r_overflow_err <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      if (w_complete) begin
        r_done_count <= r_done_count + 1'b1;
      end
      if (w_ovf_set) begin
        r_overflow_err <= 1'b1;
      end else if (status_clear) begin
        r_overflow_err <= 1'b0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (status_clear) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign inval_page       = r_inval_page;
  assign inval_page_valid = r_inval_valid;
  assign busy             = !w_fifo_empty || (r_state == WAIT);
  assign fifo_full        = w_fifo_full;
  assign overflow_err     = r_overflow_err;
  assign timeout_err      = r_timeout_err;
  assign done_count       = r_done_count;

endmodule

// File: tb/tb_cci_mpf_vtp_inval_sequencer.sv
// Bench for the VTP invalidation sequencer: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_cci_mpf_vtp_inval_sequencer;
  import cci_mpf_csrs_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned T  = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  t_cci_clAddr   req_addr = '0;
  t_cci_clAddr   inval_page;
  logic          inval_page_valid;
  logic          tgl = 1'b0;
  logic          status_clear = 1'b0;
  logic          busy;
  logic          fifo_full;
  logic          overflow_err;
  logic          timeout_err;
  logic [CW-1:0] done_count;

  cci_mpf_vtp_inval_sequencer #(
    .N_ENTRIES      (N),
    .TIMEOUT_CYCLES (T),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .req_valid             (req_valid),
    .req_addr              (req_addr),
    .inval_page            (inval_page),
    .inval_page_valid      (inval_page_valid),
    .inval_complete_toggle (tgl),
    .status_clear          (status_clear),
    .busy                  (busy),
    .fifo_full             (fifo_full),
    .overflow_err          (overflow_err),
    .timeout_err           (timeout_err),
    .done_count            (done_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus bookkeeping
  int cyc = 0;
  int flip_at = -1;
  int lat = -1;
  bit rnd_flips = 0;
  int n_valid_obs = 0;

  // Reference model: pending requests, in-flight flag and visible outputs
  t_cci_clAddr m_q[$];
  bit          m_wait;
  logic        m_ref;
  int          m_issue_cyc;
  t_cci_clAddr m_page;
  bit          m_valid;
  int          m_done;
  bit          m_ovf;
  bit          m_tmo;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_wait = 0;
    m_ref = 1'b0;
    m_issue_cyc = 0;
    m_page = '0;
    m_valid = 0;
    m_done = 0;
    m_ovf = 0;
    m_tmo = 0;
    flip_at = -1;
  endtask

  task automatic compare_outputs();
    bit exp_busy;
    bit exp_full;
    exp_busy = (m_q.size() != 0) || m_wait;
    exp_full = (m_q.size() == N);
    check_eq("inval_page", 64'(inval_page), 64'(m_page));
    check_eq("inval_page_valid", 64'(inval_page_valid), 64'(m_valid));
    check_eq("busy", 64'(busy), 64'(exp_busy));
    check_eq("fifo_full", 64'(fifo_full), 64'(exp_full));
    check_eq("overflow_err", 64'(overflow_err), 64'(m_ovf));
    check_eq("timeout_err", 64'(timeout_err), 64'(m_tmo));
    check_eq("done_count", 64'(done_count), 64'(m_done));
  endtask

  // Applies one clock of the behavioural rules to the model
  task automatic model_update(input logic r, input t_cci_clAddr a, input logic t, input logic c);
    bit pop;
    bit ovf_set;
    bit tmo_set;
    pop = !m_wait && (m_q.size() != 0);
    ovf_set = r && (m_q.size() == N) && !pop;
    tmo_set = 0;
    m_valid = 0;
    if (m_wait) begin
      if (t != m_ref) begin
        m_done = (m_done + 1) % (1 << CW);
        m_wait = 0;
      end else if (cyc - m_issue_cyc == int'(T) - 1) begin
        tmo_set = 1;
        m_wait = 0;
      end
    end else if (pop) begin
      m_page = m_q.pop_front();
      m_valid = 1;
      m_ref = t;
      m_wait = 1;
      m_issue_cyc = cyc + 1;
      flip_at = (lat >= 0) ? cyc + 1 + lat : -1;
    end
    if (r && !ovf_set) m_q.push_back(a);
    m_ovf = ovf_set ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_tmo = tmo_set ? 1'b1 : (c ? 1'b0 : m_tmo);
  endtask

  // One clock: check outputs, drive inputs, advance model, wait for the edge
  task automatic step(input logic r, input t_cci_clAddr a, input logic c);
    @(negedge clk);
    compare_outputs();
    if (inval_page_valid === 1'b1) n_valid_obs++;
    if (cyc == flip_at) tgl = ~tgl;
    else if (rnd_flips && !m_wait && ($urandom_range(0, 29) == 0)) tgl = ~tgl;
    req_valid = r;
    req_addr = a;
    status_clear = c;
    model_update(r, a, tgl, c);
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_inval_page", 64'(inval_page), 64'(0));
    check_eq("rst_valid", 64'(inval_page_valid), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_fifo_full", 64'(fifo_full), 64'(0));
    check_eq("rst_overflow", 64'(overflow_err), 64'(0));
    check_eq("rst_timeout", 64'(timeout_err), 64'(0));
    check_eq("rst_done_count", 64'(done_count), 64'(0));
  endtask

  // Asserts reset away from any clock edge and checks it takes effect at once
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    req_valid = 1'b0;
    status_clear = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_clear();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Single request completing 5 cycles after issue
    lat = 5;
    n_valid_obs = 0;
    step(1'b1, 42'h123, 1'b0);
    idle(12);
    check_eq("single_issue_count", 64'(n_valid_obs), 64'(1));
    check_eq("single_done", 64'(done_count), 64'(1));
    check_eq("single_busy_low", 64'(busy), 64'(0));

    // Eight back-to-back requests, 3-cycle completion latency
    lat = 3;
    n_valid_obs = 0;
    for (int i = 0; i < 8; i++) step(1'b1, t_cci_clAddr'(42'h10 + i), 1'b0);
    idle(50);
    check_eq("burst_issue_count", 64'(n_valid_obs), 64'(8));
    check_eq("burst_done", 64'(done_count), 64'(9));

    // Ten requests with no completion: one issued, eight buffered, one dropped
    lat = -1;
    for (int i = 0; i < 10; i++) step(1'b1, t_cci_clAddr'(42'h200 + i), 1'b0);
    idle(1);
    check_eq("ovf_flag", 64'(overflow_err), 64'(1));
    check_eq("ovf_full", 64'(fifo_full), 64'(1));
    step(1'b0, '0, 1'b1);
    idle(1);
    check_eq("clr_keeps_full", 64'(fifo_full), 64'(1));
    check_eq("clr_ovf", 64'(overflow_err), 64'(0));
    // Every entry times out in turn
    idle(9 * (T + 1) + 5);
    check_eq("drain_timeout", 64'(timeout_err), 64'(1));
    check_eq("drain_busy", 64'(busy), 64'(0));
    step(1'b0, '0, 1'b1);

    // Late toggle after a timeout is ignored
    lat = int'(T) + 10;
    step(1'b1, 42'h3AB, 1'b0);
    idle(int'(T) + 20);
    check_eq("late_tmo", 64'(timeout_err), 64'(1));
    check_eq("late_done", 64'(done_count), 64'(9));
    step(1'b0, '0, 1'b1);

    // Toggle arrives exactly on the timeout cycle: completion wins
    lat = int'(T) - 1;
    step(1'b1, 42'h3CD, 1'b0);
    idle(int'(T) + 4);
    check_eq("race_tmo", 64'(timeout_err), 64'(0));
    check_eq("race_done", 64'(done_count), 64'(10));

    // Overflow coinciding with status_clear keeps the flag set
    lat = -1;
    for (int i = 0; i < 9; i++) step(1'b1, t_cci_clAddr'(42'h400 + i), 1'b0);
    step(1'b1, 42'h4FF, 1'b1);
    idle(1);
    check_eq("ovf_vs_clr", 64'(overflow_err), 64'(1));
    do_reset();

    // Reset while waiting with three entries queued
    lat = -1;
    for (int i = 0; i < 4; i++) step(1'b1, t_cci_clAddr'(42'h500 + i), 1'b0);
    idle(3);
    check_eq("pre_rst_busy", 64'(busy), 64'(1));
    do_reset();
    n_valid_obs = 0;
    idle(2);
    tgl = ~tgl;
    idle(6);
    check_eq("post_rst_no_issue", 64'(n_valid_obs), 64'(0));
    check_eq("post_rst_done", 64'(done_count), 64'(0));
    lat = 2;
    step(1'b1, 42'h600, 1'b0);
    idle(8);
    check_eq("post_rst_done1", 64'(done_count), 64'(1));

    // Random traffic with mixed latencies, spurious toggles and clears
    rnd_flips = 1;
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6) lat = int'($urandom_range(1, 6));
      else if (sel == 6) lat = int'(T) - 1;
      else if (sel == 7) lat = int'(T) + 3;
      else lat = -1;
      step(($urandom_range(0, 2) == 0), t_cci_clAddr'({$urandom, $urandom}),
           ($urandom_range(0, 19) == 0));
    end
    rnd_flips = 0;
    lat = 1;
    idle(9 * (T + 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
